// File: rtl/wb_regfile.sv
// Write-back stage and integer register file.
// Selects the write-back value, commits it into a 32-entry register file
// (x0 reads as zero), serves two read ports with same-cycle bypass and
// counts commits for performance monitoring.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  loadData_in,
  input  logic [XLEN-1:0]  sum_out_in,
  input  logic [XLEN-1:0]  result_in,
  input  logic [1:0]       controlRF_in,
  input  logic             we_in,
  input  logic [4:0]       rd_in,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             cnt_clr,
  output logic [XLEN-1:0]  rd1,
  output logic [XLEN-1:0]  rd2,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_valid,
  output logic [CNT_W-1:0] commit_cnt
);

  logic [XLEN-1:0]  regs [32];
  logic [CNT_W-1:0] cnt_q;

  // Write-back source select; code 11 is reserved and behaves like 00.
  always_comb begin
    wb_data = result_in;
    case (controlRF_in)
      2'b01:   wb_data = loadData_in;
      2'b10:   wb_data = sum_out_in;
      default: wb_data = result_in;
    endcase
  end

  assign wb_valid = we_in && (rd_in != 5'd0);

  // Register array: async clear, commit on rising edge when a real write occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[rd_in] <= wb_data;
    end
  end

  // Read ports: x0 forced to zero, then bypass of the value committing now.
  always_comb begin
    rd1 = regs[rs1];
    if (rs1 == 5'd0) begin
      rd1 = '0;
    end else if (wb_valid && (rs1 == rd_in)) begin
      rd1 = wb_data;
    end
  end

  // Second read port, identical rule to the first.
  always_comb begin
    rd2 = regs[rs2];
    if (rs2 == 5'd0) begin
      rd2 = '0;
    end else if (wb_valid && (rs2 == rd_in)) begin
      rd2 = wb_data;
    end
  end

  // Commit counter: clear wins over a simultaneous commit, wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (wb_valid) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile. A second instance with a 3-bit counter
// shares all inputs so counter wrap-around can be reached quickly.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] load_data;
  logic [31:0] sum_out;
  logic [31:0] result;
  logic [1:0]  ctrl_rf;
  logic        we;
  logic [4:0]  rd_idx;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        cnt_clr;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic [31:0] commit_cnt;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_wb_data;
  logic        w_wb_valid;
  logic [2:0]  w_commit_cnt;

  int checks = 0;
  int errors = 0;

  wb_regfile #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .loadData_in(load_data), .sum_out_in(sum_out),
    .result_in(result), .controlRF_in(ctrl_rf), .we_in(we), .rd_in(rd_idx),
    .rs1(rs1), .rs2(rs2), .cnt_clr(cnt_clr), .rd1(rd1), .rd2(rd2),
    .wb_data(wb_data), .wb_valid(wb_valid), .commit_cnt(commit_cnt)
  );

  wb_regfile #(.XLEN(32), .CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .loadData_in(load_data), .sum_out_in(sum_out),
    .result_in(result), .controlRF_in(ctrl_rf), .we_in(we), .rd_in(rd_idx),
    .rs1(rs1), .rs2(rs2), .cnt_clr(cnt_clr), .rd1(w_rd1), .rd2(w_rd2),
    .wb_data(w_wb_data), .wb_valid(w_wb_valid), .commit_cnt(w_commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] d, input logic [1:0] sel,
                       input logic [31:0] res, input logic [31:0] ld, input logic [31:0] sm);
    we = w; rd_idx = d; ctrl_rf = sel; result = res; load_data = ld; sum_out = sm;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    we = 1'b0; rd_idx = 5'd0; ctrl_rf = 2'b00;
    result = '0; load_data = '0; sum_out = '0;
    #12 rst_n = 1'b1;
    rs1 = 5'd5; rs2 = 5'd31; #1;
    check("reset_rd1", rd1, 32'h0);
    check("reset_rd2", rd2, 32'h0);
    check("reset_cnt", commit_cnt, 32'h0);

    // write-back select mux
    drive(1'b1, 5'd3, 2'b00, 32'h11, 32'h0, 32'h0);
    check("sel00_wb", wb_data, 32'h11);
    check("sel00_valid", {31'h0, wb_valid}, 32'h1);
    step();
    drive(1'b1, 5'd4, 2'b01, 32'h99, 32'h22, 32'h0);
    check("sel01_wb", wb_data, 32'h22);
    step();
    drive(1'b1, 5'd5, 2'b10, 32'h99, 32'h22, 32'h104);
    check("sel10_wb", wb_data, 32'h104);
    step();
    drive(1'b0, 5'd6, 2'b11, 32'h33, 32'h44, 32'h55);
    check("sel11_wb", wb_data, 32'h33);
    rs1 = 5'd3; rs2 = 5'd4; #1;
    check("x3", rd1, 32'h11);
    check("x4", rd2, 32'h22);
    rs1 = 5'd5; #1;
    check("x5", rd1, 32'h104);
    check("cnt3", commit_cnt, 32'd3);
    step();
    check("we0_no_count", commit_cnt, 32'd3);

    // x0 protection
    rs1 = 5'd0;
    drive(1'b1, 5'd0, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0);
    check("x0_rd1", rd1, 32'h0);
    check("x0_valid", {31'h0, wb_valid}, 32'h0);
    check("x0_wb", wb_data, 32'hDEADBEEF);
    step();
    check("x0_rd1_after", rd1, 32'h0);
    check("x0_cnt", commit_cnt, 32'd3);

    // bypass
    drive(1'b1, 5'd7, 2'b00, 32'h5, 32'h0, 32'h0);
    step();
    rs1 = 5'd7; rs2 = 5'd7;
    drive(1'b1, 5'd7, 2'b00, 32'hABCD, 32'h0, 32'h0);
    check("byp_rd1", rd1, 32'hABCD);
    check("byp_rd2", rd2, 32'hABCD);
    drive(1'b0, 5'd7, 2'b00, 32'hABCD, 32'h0, 32'h0);
    check("nobyp_rd1", rd1, 32'h5);
    check("nobyp_rd2", rd2, 32'h5);
    step();
    check("x7_kept", rd1, 32'h5);
    check("cnt4", commit_cnt, 32'd4);

    // clear has priority, register still written
    cnt_clr = 1'b1;
    drive(1'b1, 5'd8, 2'b00, 32'h88, 32'h0, 32'h0);
    step();
    cnt_clr = 1'b0;
    rs1 = 5'd8;
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    check("clr_cnt", commit_cnt, 32'd0);
    check("clr_x8", rd1, 32'h88);

    // wrap on the 3-bit counter instance
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5'd10, 2'b00, 32'h100 + i, 32'h0, 32'h0);
      step();
    end
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    check("cnt7", commit_cnt, 32'd7);
    check("w_cnt7", {29'h0, w_commit_cnt}, 32'd7);
    drive(1'b1, 5'd10, 2'b00, 32'h200, 32'h0, 32'h0);
    step();
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    rs1 = 5'd10; #1;
    check("cnt8", commit_cnt, 32'd8);
    check("w_wrap", {29'h0, w_commit_cnt}, 32'd0);
    check("w_x10", w_rd1, 32'h200);

    // async reset mid-operation
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    drive(1'b1, 5'd9, 2'b00, 32'h77, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd11, 2'b01, 32'h0, 32'h1234, 32'h0);
    step();
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    rs1 = 5'd9; rs2 = 5'd11; #1;
    check("pre_rst_x9", rd1, 32'h77);
    check("pre_rst_cnt", commit_cnt, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_x9", rd1, 32'h0);
    check("rst_x11", rd2, 32'h0);
    check("rst_cnt", commit_cnt, 32'd0);
    drive(1'b1, 5'd9, 2'b00, 32'h55, 32'h0, 32'h0);
    check("rst_byp", rd1, 32'h55);
    step();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    check("rst_nocommit", rd1, 32'h0);
    check("rst_nocount", commit_cnt, 32'd0);
    drive(1'b1, 5'd12, 2'b10, 32'h0, 32'h0, 32'hC0DE);
    step();
    drive(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    rs1 = 5'd12; #1;
    check("post_rst_x12", rd1, 32'hC0DE);
    check("post_rst_cnt", commit_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
